// File: rtl/sha1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha1_pkg
// Brief    : Shared SHA-1 digest constants and types.
// Revision : 1.0 - initial release
// ============================================================================
package sha1_pkg;

   localparam int SHA1_DIGEST_WORDS = 5;
   localparam int SHA1_DIGEST_WIDTH = 160;

   typedef logic [SHA1_DIGEST_WIDTH-1:0] sha1_digest_t;

endpackage : sha1_pkg
`default_nettype wire

// File: rtl/sha1_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : sha1_result_collector
// Brief    : Assembles 32-bit FWFT result words into 160-bit SHA-1 digests with
//            a double-buffered valid/ready output. Optional macro
//            SHA1_RES_TAG_EN adds a leading header word whose low bits tag
//            the digest.
// Revision : 1.0 - initial release
// ============================================================================
module sha1_result_collector
   import sha1_pkg::*;
#(
   parameter int TAG_DATA_WIDTH = 14,
   parameter int RES_DATA_WIDTH = 32
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [RES_DATA_WIDTH-1:0] result_dout,
   input  logic                      result_data_empty,
   output logic                      result_data_fifo_ren,
   input  logic                      clr,
   output logic [159:0]              digest_data,
   output logic [TAG_DATA_WIDTH-1:0] digest_tag,
   output logic                      digest_val,
   input  logic                      digest_rdy,
   output logic [31:0]               digest_cnt
);

`ifdef SHA1_RES_TAG_EN
   localparam logic [2:0] LAST = 3'd5;
`else
   localparam logic [2:0] LAST = 3'd4;
`endif
   // The final word bypasses the assembly register straight into the output.
   localparam int ASM_WIDTH = SHA1_DIGEST_WIDTH - RES_DATA_WIDTH;

   logic [2:0]           word_idx_q, word_idx_d;
   logic [ASM_WIDTH-1:0] asm_q, asm_d;
   sha1_digest_t         digest_q, digest_d;
   logic                 val_q, val_d;
   logic [31:0]          cnt_q, cnt_d;

   logic pop;
   logic data_pop;
   logic last_pop;
   logic xfer;
   logic stall;

   assign xfer     = val_q & digest_rdy;
   assign stall    = (word_idx_q == LAST) & val_q & ~digest_rdy;
   assign pop      = ~result_data_empty & ~clr & ~stall & ~sys_rst;
   assign last_pop = pop & (word_idx_q == LAST);

   assign result_data_fifo_ren = pop;

   always_comb begin
      word_idx_d = word_idx_q;
      asm_d      = asm_q;
      if (clr) begin
         word_idx_d = 3'd0;
         asm_d      = '0;
      end else if (pop) begin
         word_idx_d = (word_idx_q == LAST) ? 3'd0 : word_idx_q + 3'd1;
         if (data_pop) begin
            asm_d = {asm_q[ASM_WIDTH-RES_DATA_WIDTH-1:0], result_dout};
         end
      end
   end

   always_comb begin
      digest_d = digest_q;
      val_d    = val_q;
      cnt_d    = cnt_q;
      if (last_pop) begin
         digest_d = {asm_q, result_dout};
         val_d    = 1'b1;
      end else if (xfer) begin
         val_d    = 1'b0;
      end
      if (xfer) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         word_idx_q <= 3'd0;
         asm_q      <= '0;
         digest_q   <= '0;
         val_q      <= 1'b0;
         cnt_q      <= 32'd0;
      end else begin
         word_idx_q <= word_idx_d;
         asm_q      <= asm_d;
         digest_q   <= digest_d;
         val_q      <= val_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef SHA1_RES_TAG_EN
   logic [TAG_DATA_WIDTH-1:0] hdr_tag_q, hdr_tag_d;
   logic [TAG_DATA_WIDTH-1:0] tag_q, tag_d;
   logic                      unused_hdr_bits;

   // Word 0 is the header; it never enters the digest shift register.
   assign data_pop        = pop & (word_idx_q != 3'd0);
   assign unused_hdr_bits = ^result_dout[RES_DATA_WIDTH-1:TAG_DATA_WIDTH];

   always_comb begin
      hdr_tag_d = hdr_tag_q;
      tag_d     = tag_q;
      if (clr) begin
         hdr_tag_d = '0;
      end else if (pop && (word_idx_q == 3'd0)) begin
         hdr_tag_d = result_dout[TAG_DATA_WIDTH-1:0];
      end
      if (last_pop) begin
         tag_d = hdr_tag_q;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hdr_tag_q <= '0;
         tag_q     <= '0;
      end else begin
         hdr_tag_q <= hdr_tag_d;
         tag_q     <= tag_d;
      end
   end

   assign digest_tag = tag_q;
`else
   assign data_pop   = pop;
   assign digest_tag = '0;
`endif

   assign digest_data = digest_q;
   assign digest_val  = val_q;
   assign digest_cnt  = cnt_q;

endmodule : sha1_result_collector
`default_nettype wire

// File: tb/tb_sha1_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha1_result_collector
// Brief    : Directed self-checking bench; FIFO modelled as a queue. Build with
//            SHA1_RES_TAG_EN defined to exercise the tagged header format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha1_result_collector;
   import sha1_pkg::*;

   localparam int TW = 14;
`ifdef SHA1_RES_TAG_EN
   localparam int NW = 6;
`else
   localparam int NW = 5;
`endif

   localparam logic [159:0] D_A = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
   localparam logic [159:0] D_B = 160'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [159:0] D_C = 160'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0_00000001;
   localparam logic [159:0] D_D = 160'h13579BDF_2468ACE0_FFFFFFFF_00000000_80000000;
   localparam logic [159:0] D_E = 160'h0BADF00D_CAFEBABE_11223344_55667788_99AABBCC;
   localparam logic [159:0] D_F = 160'h01010101_02020202_03030303_04040404_05050505;
   localparam logic [159:0] D_G = 160'hFEEDFACE_8BADF00D_DEADC0DE_1BADB002_ABCDEF01;
   localparam logic [159:0] D_J = 160'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB;

   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic             clr = 1'b0;
   logic             digest_rdy = 1'b0;
   logic [31:0]      result_dout = 32'h0;
   logic             result_data_empty = 1'b1;
   logic             result_data_fifo_ren;
   logic [159:0]     digest_data;
   logic [TW-1:0]    digest_tag;
   logic             digest_val;
   logic [31:0]      digest_cnt;

   logic [31:0]      fifo[$];
   int               n_checks = 0;
   int               n_fail = 0;
   logic [31:0]      exp_cnt;

   sha1_result_collector #(
      .TAG_DATA_WIDTH(TW),
      .RES_DATA_WIDTH(32)
   ) dut (
      .sys_clk             (sys_clk),
      .sys_rst             (sys_rst),
      .result_dout         (result_dout),
      .result_data_empty   (result_data_empty),
      .result_data_fifo_ren(result_data_fifo_ren),
      .clr                 (clr),
      .digest_data         (digest_data),
      .digest_tag          (digest_tag),
      .digest_val          (digest_val),
      .digest_rdy          (digest_rdy),
      .digest_cnt          (digest_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] hdr, input logic [159:0] d, input int i);
      if (NW == 6 && i == 0) return hdr;
      return d[159 - 32*(i - (NW - 5)) -: 32];
   endfunction

   function automatic logic [TW-1:0] exp_tag(input logic [31:0] hdr);
      return (NW == 6) ? hdr[TW-1:0] : '0;
   endfunction

   task automatic fifo_out();
      result_data_empty = (fifo.size() == 0);
      result_dout       = (fifo.size() != 0) ? fifo[0] : 32'h0;
   endtask

   task automatic push_range(input logic [31:0] hdr, input logic [159:0] d, input int from, input int to);
      for (int i = from; i <= to; i++) fifo.push_back(word_at(hdr, d, i));
      fifo_out();
   endtask

   // The DUT consumes the head word at the edge; the queue catches up just after it.
   task automatic tick();
      logic r;
      @(negedge sys_clk);
      r = result_data_fifo_ren;
      @(posedge sys_clk);
      #1;
      if (r) begin
         chk("pop_nonempty", fifo.size() != 0, 1'b1);
         if (fifo.size() != 0) void'(fifo.pop_front());
      end
      fifo_out();
      #1;
   endtask

   task automatic wait_val(input string tag, output int n);
      n = 0;
      while (!digest_val && n < 40) begin
         tick();
         n++;
      end
      chk(tag, digest_val, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      fifo_out();
      repeat (3) tick();
      chk("rst_val", digest_val, 1'b0);
      chk("rst_data", digest_data, 160'h0);
      chk("rst_tag", digest_tag, '0);
      chk("rst_cnt", digest_cnt, 32'h0);
      chk("rst_ren", result_data_fifo_ren, 1'b0);
      sys_rst = 1'b0;
      exp_cnt = 32'd0;

      // Single digest, downstream always ready
      digest_rdy = 1'b1;
      push_range(32'h00002A5C, D_A, 0, NW-1);
      #1;
      chk("t1_ren", result_data_fifo_ren, 1'b1);
      wait_val("t1_val", n);
      chk("t1_latency", n, NW);
      chk("t1_data", digest_data, D_A);
      chk("t1_tag", digest_tag, exp_tag(32'h00002A5C));
      tick();
      exp_cnt++;
      chk("t1_cnt", digest_cnt, exp_cnt);
      chk("t1_val_clear", digest_val, 1'b0);

      // Back-to-back digests with downstream stalled
      digest_rdy = 1'b0;
      push_range(32'hFFFF0001, D_B, 0, NW-1);
      push_range(32'h12343FFF, D_C, 0, NW-1);
      wait_val("t2_val1", n);
      repeat (8) tick();
      chk("t2_stall_ren", result_data_fifo_ren, 1'b0);
      chk("t2_fifo_left", fifo.size(), 1);
      chk("t2_hold_val", digest_val, 1'b1);
      chk("t2_hold_data", digest_data, D_B);
      chk("t2_hold_tag", digest_tag, exp_tag(32'hFFFF0001));
      chk("t2_hold_cnt", digest_cnt, exp_cnt);
      digest_rdy = 1'b1;
      #1;
      chk("t2_ren_resume", result_data_fifo_ren, 1'b1);
      tick();
      exp_cnt++;
      chk("t2_val2", digest_val, 1'b1);
      chk("t2_data2", digest_data, D_C);
      chk("t2_tag2", digest_tag, exp_tag(32'h12343FFF));
      chk("t2_cnt1", digest_cnt, exp_cnt);
      tick();
      exp_cnt++;
      chk("t2_cnt2", digest_cnt, exp_cnt);
      chk("t2_val_clear", digest_val, 1'b0);

      // clr discards a partial digest
      push_range(32'h00000BAD, D_J, 0, 2);
      repeat (3) tick();
      clr = 1'b1;
      push_range(32'h00001234, D_D, 0, NW-1);
      #1;
      chk("t3_clr_ren", result_data_fifo_ren, 1'b0);
      tick();
      clr = 1'b0;
      wait_val("t3_val", n);
      chk("t3_latency", n, NW);
      chk("t3_data", digest_data, D_D);
      chk("t3_tag", digest_tag, exp_tag(32'h00001234));
      tick();
      exp_cnt++;
      chk("t3_cnt", digest_cnt, exp_cnt);

      // Reset mid-assembly with a digest pending
      digest_rdy = 1'b0;
      push_range(32'h00000777, D_E, 0, NW-1);
      push_range(32'h00000BAD, D_J, 0, 1);
      wait_val("t4_val_pre", n);
      repeat (3) tick();
      chk("t4_pre_data", digest_data, D_E);
      sys_rst = 1'b1;
      #1;
      chk("t4_rst_val", digest_val, 1'b0);
      chk("t4_rst_data", digest_data, 160'h0);
      chk("t4_rst_tag", digest_tag, '0);
      chk("t4_rst_cnt", digest_cnt, 32'h0);
      push_range(32'h00003ABC, D_F, 0, NW-1);
      #1;
      chk("t4_rst_ren", result_data_fifo_ren, 1'b0);
      tick();
      chk("t4_no_pop", fifo.size(), NW);
      sys_rst = 1'b0;
      exp_cnt = 32'd0;
      digest_rdy = 1'b1;
      wait_val("t4_val", n);
      chk("t4_latency", n, NW);
      chk("t4_data", digest_data, D_F);
      chk("t4_tag", digest_tag, exp_tag(32'h00003ABC));
      tick();
      exp_cnt++;
      chk("t4_cnt", digest_cnt, exp_cnt);

      // FIFO empty for 10 cycles in the middle of an assembly
      push_range(32'h00000055, D_G, 0, 1);
      repeat (2) tick();
      for (int i = 0; i < 10; i++) begin
         chk("t6_idle_ren", result_data_fifo_ren, 1'b0);
         chk("t6_idle_val", digest_val, 1'b0);
         tick();
      end
      chk("t6_word_idx", dut.word_idx_q, 3'd2);
      push_range(32'h00000055, D_G, 2, NW-1);
      wait_val("t6_val", n);
      chk("t6_latency", n, NW-2);
      chk("t6_data", digest_data, D_G);
      chk("t6_tag", digest_tag, exp_tag(32'h00000055));
      tick();
      exp_cnt++;
      chk("t6_cnt", digest_cnt, exp_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sha1_result_collector
`default_nettype wire
